// File: rtl/sram_uart_dump_pkg.sv
// Shared types and constants for the SRAM-to-UART image dumper.
package sram_uart_dump_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_ADDR,
    S_RD_WAIT,
    S_RD_LATCH,
    S_TX_HI,
    S_TX_LO,
    S_DONE
  } state_t;

  localparam int UART_FRAME_BITS  = 10;
  localparam int DEFAULT_BAUD_DIV = 434;
  localparam int IMG_WORD_COUNT   = 115200;

endpackage

// File: rtl/sram_uart_dump_tx.sv
// 8N1 byte serializer; tx_busy drops in the last stop-bit cycle so a new
// byte accepted there starts with zero idle time on the line.
module uart_tx_byte
  import sram_uart_dump_pkg::*;
#(
  parameter int BAUD_DIV = DEFAULT_BAUD_DIV
) (
  input  logic       Clock_50,
  input  logic       Reset,
  input  logic       tx_start,
  input  logic [7:0] tx_data,
  output logic       tx_busy,
  output logic       UART_TX_O
);

  localparam int BW = $clog2(BAUD_DIV);
  localparam logic [BW-1:0] BAUD_LAST = BW'(BAUD_DIV - 1);
  localparam logic [3:0] BIT_LAST = 4'(UART_FRAME_BITS - 1);

  logic          active_q;
  logic [BW-1:0] baud_q;
  logic [3:0]    bit_q;
  logic [9:0]    sh_q;
  logic          tx_q;
  logic          bit_end;
  logic          frame_end;

  assign bit_end   = (baud_q == BAUD_LAST);
  assign frame_end = bit_end && (bit_q == BIT_LAST);
  assign tx_busy   = active_q && !frame_end;
  assign UART_TX_O = tx_q;

  always_ff @(posedge Clock_50) begin
    if (Reset) begin
      active_q <= 1'b0;
      baud_q   <= '0;
      bit_q    <= '0;
      sh_q     <= '1;
      tx_q     <= 1'b1;
    end else if (tx_start && !tx_busy) begin
      active_q <= 1'b1;
      baud_q   <= '0;
      bit_q    <= '0;
      sh_q     <= {1'b1, tx_data, 1'b0};
      tx_q     <= 1'b0;
    end else if (active_q) begin
      if (bit_end) begin
        baud_q <= '0;
        if (frame_end) begin
          active_q <= 1'b0;
          tx_q     <= 1'b1;
        end else begin
          bit_q <= bit_q + 4'd1;
          sh_q  <= {1'b1, sh_q[9:1]};
          tx_q  <= sh_q[1];
        end
      end else begin
        baud_q <= baud_q + 1'b1;
      end
    end
  end

endmodule

// File: rtl/sram_uart_dump.sv
// Reads WORD_COUNT SRAM words from START_ADDR and streams them out of the
// UART, high byte first, prefetching the next word during the low byte.
module sram_uart_dump
  import sram_uart_dump_pkg::*;
#(
  parameter int          BAUD_DIV   = DEFAULT_BAUD_DIV,
  parameter logic [17:0] START_ADDR = 18'd0,
  parameter int          WORD_COUNT = IMG_WORD_COUNT
) (
  input  logic        Clock_50,
  input  logic        Reset,
  input  logic        Start,
  output logic [17:0] SRAM_address,
  output logic        SRAM_we_n,
  input  logic [15:0] SRAM_read_data,
  output logic        Busy,
  output logic        Done,
  output logic        UART_TX_O
);

  if ((int'(START_ADDR) + WORD_COUNT) > (1 << 18)) begin : g_addr_chk
    $error("START_ADDR + WORD_COUNT exceeds the 18-bit SRAM space");
  end
  if (WORD_COUNT < 1 || BAUD_DIV < 2) begin : g_par_chk
    $error("WORD_COUNT must be >= 1 and BAUD_DIV >= 2");
  end

  localparam logic [17:0] CNT_LAST = 18'(WORD_COUNT - 1);

  state_t      state_q;
  logic [17:0] addr_q;
  logic [17:0] cnt_q;
  logic [15:0] word_buf_q;
  logic [15:0] next_buf_q;
  logic [2:0]  pf_q;
  logic        first_q;
  logic        busy_q;
  logic        done_q;

  logic        tx_start;
  logic [7:0]  tx_data;
  logic        tx_busy;
  logic        last;
  logic        prefetch;

  assign last         = (cnt_q == CNT_LAST);
  assign SRAM_address = addr_q;
  assign SRAM_we_n    = 1'b1;
  assign Busy         = busy_q;
  assign Done         = done_q;

  // Bytes are handed over in the same cycle the serializer frees up.
  always_comb begin
    tx_start = 1'b0;
    tx_data  = word_buf_q[15:8];
    prefetch = 1'b0;
    unique case (state_q)
      S_TX_HI: begin
        if (!tx_busy) begin
          tx_start = 1'b1;
          tx_data  = first_q ? word_buf_q[15:8] : word_buf_q[7:0];
          prefetch = !first_q && !last;
        end
      end
      S_TX_LO: begin
        if (!tx_busy && !last) begin
          tx_start = 1'b1;
          tx_data  = next_buf_q[15:8];
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge Clock_50) begin
    if (Reset) begin
      state_q    <= S_IDLE;
      addr_q     <= START_ADDR;
      cnt_q      <= '0;
      word_buf_q <= '0;
      next_buf_q <= '0;
      pf_q       <= '0;
      first_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      pf_q   <= {pf_q[1:0], prefetch};
      if (pf_q[2]) next_buf_q <= SRAM_read_data;
      if (prefetch) addr_q <= addr_q + 18'd1;
      unique case (state_q)
        S_IDLE: begin
          if (Start) begin
            busy_q  <= 1'b1;
            cnt_q   <= '0;
            addr_q  <= START_ADDR;
            state_q <= S_RD_ADDR;
          end
        end
        S_RD_ADDR:  state_q <= S_RD_WAIT;
        S_RD_WAIT:  state_q <= S_RD_LATCH;
        S_RD_LATCH: begin
          word_buf_q <= SRAM_read_data;
          first_q    <= 1'b1;
          state_q    <= S_TX_HI;
        end
        S_TX_HI: begin
          if (!tx_busy) begin
            if (first_q) first_q <= 1'b0;
            else         state_q <= S_TX_LO;
          end
        end
        S_TX_LO: begin
          if (!tx_busy) begin
            if (last) begin
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              addr_q  <= START_ADDR;
              state_q <= S_DONE;
            end else begin
              word_buf_q <= next_buf_q;
              cnt_q      <= cnt_q + 18'd1;
              state_q    <= S_TX_HI;
            end
          end
        end
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  uart_tx_byte #(
    .BAUD_DIV(BAUD_DIV)
  ) u_tx (
    .Clock_50 (Clock_50),
    .Reset    (Reset),
    .tx_start (tx_start),
    .tx_data  (tx_data),
    .tx_busy  (tx_busy),
    .UART_TX_O(UART_TX_O)
  );

endmodule
